// File: rtl/d_cache_fm_req_q.sv
// Far-memory request queue: in-order fills/writebacks to FM, outstanding-read limit, FM read responses back to the TQ.
// Optional D_CACHE_FMQ_RSP_REG_EN: registers the fm2cache_* response path (1-cycle latency).
module d_cache_fm_req_q #(
  parameter int DEPTH     = 8,
  parameter int CL_ADDR_W = 28,
  parameter int CL_DATA_W = 128,
  parameter int TQ_ID_W   = 3,
  parameter int MAX_OUTST = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 miss_rd_valid,
  input  logic [TQ_ID_W-1:0]   miss_rd_tq_id,
  input  logic [CL_ADDR_W-1:0] miss_rd_cl_addr,
  input  logic                 evict_wr_valid,
  input  logic [CL_ADDR_W-1:0] evict_wr_cl_addr,
  input  logic [CL_DATA_W-1:0] evict_wr_cl_data,
  output logic                 fmq_stall,
  output logic                 fm_req_valid,
  input  logic                 fm_req_ready,
  output logic                 fm_req_is_wr,
  output logic [CL_ADDR_W-1:0] fm_req_cl_addr,
  output logic [CL_DATA_W-1:0] fm_req_cl_data,
  output logic [TQ_ID_W-1:0]   fm_req_tq_id,
  input  logic                 fm_rsp_valid,
  input  logic [TQ_ID_W-1:0]   fm_rsp_tq_id,
  input  logic [CL_DATA_W-1:0] fm_rsp_cl_data,
  output logic                 fm2cache_valid,
  output logic [TQ_ID_W-1:0]   fm2cache_tq_id,
  output logic [CL_DATA_W-1:0] fm2cache_cl_data,
  output logic                 fmq_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OST_W = $clog2(MAX_OUTST + 1);

  typedef struct packed {
    logic                 is_wr;
    logic [CL_ADDR_W-1:0] addr;
    logic [CL_DATA_W-1:0] data;
    logic [TQ_ID_W-1:0]   tq_id;
  } fmq_entry_t;

  fmq_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, mi_idx;
  logic [CNT_W-1:0] count_q, count_d, avail;
  logic [OST_W-1:0] outst_q, outst_d;
  logic             err_q, err_d;
  logic             req_vld, pop, ev_ok, mi_ok, drop, rd_inc, rsp_dec, rsp_orphan;
  fmq_entry_t       head;

  assign head = mem_q[rd_ptr_q];

  // A read head at the in-flight limit blocks everything behind it to keep FM order.
  assign req_vld = (count_q != '0) && !(!head.is_wr && (outst_q == OST_W'(MAX_OUTST)));
  assign pop     = req_vld && fm_req_ready;

  always_comb begin
    fm_req_valid   = 1'b0;
    fm_req_is_wr   = 1'b0;
    fm_req_cl_addr = '0;
    fm_req_cl_data = '0;
    fm_req_tq_id   = '0;
    if (req_vld) begin
      fm_req_valid   = 1'b1;
      fm_req_is_wr   = head.is_wr;
      fm_req_cl_addr = head.addr;
      fm_req_cl_data = head.data;
      fm_req_tq_id   = head.tq_id;
    end
  end

  // Slots freed by this cycle's pop are reusable by this cycle's pushes; evict takes the older slot.
  assign avail    = CNT_W'(DEPTH) - count_q + CNT_W'(pop);
  assign ev_ok    = evict_wr_valid && (avail != '0);
  assign mi_ok    = miss_rd_valid && (avail > CNT_W'(ev_ok));
  assign drop     = (evict_wr_valid && !ev_ok) || (miss_rd_valid && !mi_ok);
  assign mi_idx   = wr_ptr_q + PTR_W'(ev_ok);
  assign wr_ptr_d = wr_ptr_q + PTR_W'(ev_ok) + PTR_W'(mi_ok);
  assign rd_ptr_d = rd_ptr_q + PTR_W'(pop);
  assign count_d  = count_q + CNT_W'(ev_ok) + CNT_W'(mi_ok) - CNT_W'(pop);

  // Looks at post-update occupancy so a low stall guarantees room for two pushes next cycle.
  assign fmq_stall = (CNT_W'(DEPTH) - count_d) < CNT_W'(2);

  assign rd_inc     = pop && !head.is_wr;
  assign rsp_orphan = fm_rsp_valid && (outst_q == '0);
  assign rsp_dec    = fm_rsp_valid && !rsp_orphan;
  assign outst_d    = outst_q + OST_W'(rd_inc) - OST_W'(rsp_dec);
  assign err_d      = err_q || drop || rsp_orphan;
  assign fmq_err    = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      outst_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      outst_q  <= outst_d;
      err_q    <= err_d;
    end
  end

  // Payload storage needs no reset; visibility is governed by count_q.
  always_ff @(posedge clk) begin
    if (ev_ok)
      mem_q[wr_ptr_q] <= '{is_wr: 1'b1, addr: evict_wr_cl_addr, data: evict_wr_cl_data, tq_id: '0};
    if (mi_ok)
      mem_q[mi_idx] <= '{is_wr: 1'b0, addr: miss_rd_cl_addr, data: '0, tq_id: miss_rd_tq_id};
  end

`ifdef D_CACHE_FMQ_RSP_REG_EN
  logic                 rsp_vld_q;
  logic [TQ_ID_W-1:0]   rsp_tq_q;
  logic [CL_DATA_W-1:0] rsp_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_vld_q  <= 1'b0;
      rsp_tq_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      rsp_vld_q  <= fm_rsp_valid;
      rsp_tq_q   <= fm_rsp_tq_id;
      rsp_data_q <= fm_rsp_cl_data;
    end
  end

  assign fm2cache_valid   = rsp_vld_q;
  assign fm2cache_tq_id   = rsp_tq_q;
  assign fm2cache_cl_data = rsp_data_q;
`else
  assign fm2cache_valid   = fm_rsp_valid;
  assign fm2cache_tq_id   = fm_rsp_tq_id;
  assign fm2cache_cl_data = fm_rsp_cl_data;
`endif

endmodule

// File: tb/tb_d_cache_fm_req_q.sv
// Directed bench for d_cache_fm_req_q: order, outstanding limit, backpressure/stall, overflow, errors, async reset.
module tb_d_cache_fm_req_q;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam int TW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          miss_rd_valid;
  logic [TW-1:0] miss_rd_tq_id;
  logic [AW-1:0] miss_rd_cl_addr;
  logic          evict_wr_valid;
  logic [AW-1:0] evict_wr_cl_addr;
  logic [DW-1:0] evict_wr_cl_data;
  logic          fmq_stall, fm_req_valid, fm_req_ready, fm_req_is_wr;
  logic [AW-1:0] fm_req_cl_addr;
  logic [DW-1:0] fm_req_cl_data;
  logic [TW-1:0] fm_req_tq_id;
  logic          fm_rsp_valid;
  logic [TW-1:0] fm_rsp_tq_id;
  logic [DW-1:0] fm_rsp_cl_data;
  logic          fm2cache_valid;
  logic [TW-1:0] fm2cache_tq_id;
  logic [DW-1:0] fm2cache_cl_data;
  logic          fmq_err;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  d_cache_fm_req_q dut (
    .clk(clk), .rst(rst),
    .miss_rd_valid(miss_rd_valid), .miss_rd_tq_id(miss_rd_tq_id), .miss_rd_cl_addr(miss_rd_cl_addr),
    .evict_wr_valid(evict_wr_valid), .evict_wr_cl_addr(evict_wr_cl_addr), .evict_wr_cl_data(evict_wr_cl_data),
    .fmq_stall(fmq_stall), .fm_req_valid(fm_req_valid), .fm_req_ready(fm_req_ready),
    .fm_req_is_wr(fm_req_is_wr), .fm_req_cl_addr(fm_req_cl_addr), .fm_req_cl_data(fm_req_cl_data),
    .fm_req_tq_id(fm_req_tq_id), .fm_rsp_valid(fm_rsp_valid), .fm_rsp_tq_id(fm_rsp_tq_id),
    .fm_rsp_cl_data(fm_rsp_cl_data), .fm2cache_valid(fm2cache_valid), .fm2cache_tq_id(fm2cache_tq_id),
    .fm2cache_cl_data(fm2cache_cl_data), .fmq_err(fmq_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    checks++; if (fm_req_valid !== 1'b0) begin fails++; $display("FAIL rst_vld act=%0h exp=0", fm_req_valid); end
    checks++; if (fmq_stall !== 1'b0) begin fails++; $display("FAIL rst_stall act=%0h exp=0", fmq_stall); end
    checks++; if (fmq_err !== 1'b0) begin fails++; $display("FAIL rst_err act=%0h exp=0", fmq_err); end
    checks++; if (fm2cache_valid !== 1'b0) begin fails++; $display("FAIL rst_rspvld act=%0h exp=0", fm2cache_valid); end
    checks++; if (fm_req_cl_addr !== '0) begin fails++; $display("FAIL rst_addr act=%0h exp=0", fm_req_cl_addr); end
  endtask

  task automatic test_single_miss;
    logic [DW-1:0] aa;
    aa = {16{8'hAA}};
    miss_rd_valid = 1'b1; miss_rd_tq_id = 3'd5; miss_rd_cl_addr = 28'h123;
    tick;
    miss_rd_valid = 1'b0;
    checks++; if (fm_req_valid !== 1'b1) begin fails++; $display("FAIL single_vld act=%0h exp=1", fm_req_valid); end
    checks++; if (fm_req_is_wr !== 1'b0) begin fails++; $display("FAIL single_iswr act=%0h exp=0", fm_req_is_wr); end
    checks++; if (fm_req_tq_id !== 3'd5) begin fails++; $display("FAIL single_tq act=%0h exp=5", fm_req_tq_id); end
    checks++; if (fm_req_cl_addr !== 28'h123) begin fails++; $display("FAIL single_addr act=%0h exp=123", fm_req_cl_addr); end
    checks++; if (fm_req_cl_data !== '0) begin fails++; $display("FAIL single_data act=%0h exp=0", fm_req_cl_data); end
    fm_req_ready = 1'b1;
    tick;
    fm_req_ready = 1'b0;
    checks++; if (fm_req_valid !== 1'b0) begin fails++; $display("FAIL single_empty act=%0h exp=0", fm_req_valid); end
    fm_rsp_valid = 1'b1; fm_rsp_tq_id = 3'd5; fm_rsp_cl_data = aa;
    #1;
`ifndef D_CACHE_FMQ_RSP_REG_EN
    checks++; if (fm2cache_valid !== 1'b1) begin fails++; $display("FAIL rsp_vld act=%0h exp=1", fm2cache_valid); end
    checks++; if (fm2cache_tq_id !== 3'd5) begin fails++; $display("FAIL rsp_tq act=%0h exp=5", fm2cache_tq_id); end
    checks++; if (fm2cache_cl_data !== aa) begin fails++; $display("FAIL rsp_data act=%0h exp=%0h", fm2cache_cl_data, aa); end
`else
    checks++; if (fm2cache_valid !== 1'b0) begin fails++; $display("FAIL rsp_vld_early act=%0h exp=0", fm2cache_valid); end
`endif
    tick;
    fm_rsp_valid = 1'b0;
`ifdef D_CACHE_FMQ_RSP_REG_EN
    checks++; if (fm2cache_valid !== 1'b1) begin fails++; $display("FAIL rsp_vld act=%0h exp=1", fm2cache_valid); end
    checks++; if (fm2cache_tq_id !== 3'd5) begin fails++; $display("FAIL rsp_tq act=%0h exp=5", fm2cache_tq_id); end
    checks++; if (fm2cache_cl_data !== aa) begin fails++; $display("FAIL rsp_data act=%0h exp=%0h", fm2cache_cl_data, aa); end
`endif
    checks++; if (fmq_err !== 1'b0) begin fails++; $display("FAIL single_err act=%0h exp=0", fmq_err); end
  endtask

  task automatic test_order;
    logic [DW-1:0] d1;
    d1 = {4{32'h1111_2222}};
    evict_wr_valid = 1'b1; evict_wr_cl_addr = 28'h040; evict_wr_cl_data = d1;
    miss_rd_valid = 1'b1; miss_rd_cl_addr = 28'h080; miss_rd_tq_id = 3'd2;
    tick;
    evict_wr_valid = 1'b0; miss_rd_valid = 1'b0;
    checks++; if (fm_req_is_wr !== 1'b1) begin fails++; $display("FAIL order_wr act=%0h exp=1", fm_req_is_wr); end
    checks++; if (fm_req_cl_addr !== 28'h040) begin fails++; $display("FAIL order_wraddr act=%0h exp=40", fm_req_cl_addr); end
    checks++; if (fm_req_cl_data !== d1) begin fails++; $display("FAIL order_wrdata act=%0h exp=%0h", fm_req_cl_data, d1); end
    checks++; if (fm_req_tq_id !== 3'd0) begin fails++; $display("FAIL order_wrtq act=%0h exp=0", fm_req_tq_id); end
    fm_req_ready = 1'b1;
    tick;
    checks++; if (fm_req_valid !== 1'b1 || fm_req_is_wr !== 1'b0) begin fails++; $display("FAIL order_rd act=%0h/%0h exp=1/0", fm_req_valid, fm_req_is_wr); end
    checks++; if (fm_req_cl_addr !== 28'h080) begin fails++; $display("FAIL order_rdaddr act=%0h exp=80", fm_req_cl_addr); end
    checks++; if (fm_req_tq_id !== 3'd2) begin fails++; $display("FAIL order_rdtq act=%0h exp=2", fm_req_tq_id); end
    tick;
    fm_req_ready = 1'b0;
    checks++; if (fm_req_valid !== 1'b0) begin fails++; $display("FAIL order_empty act=%0h exp=0", fm_req_valid); end
    fm_rsp_valid = 1'b1; fm_rsp_tq_id = 3'd2;
    tick;
    fm_rsp_valid = 1'b0;
  endtask

  task automatic test_outst_limit;
    fm_req_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      miss_rd_valid = 1'b1; miss_rd_tq_id = TW'(i); miss_rd_cl_addr = AW'(28'h200 + i);
      tick;
    end
    miss_rd_valid = 1'b0;
    evict_wr_valid = 1'b1; evict_wr_cl_addr = 28'h2F0; evict_wr_cl_data = {4{32'hCAFE_F00D}};
    tick;
    evict_wr_valid = 1'b0;
    checks++; if (fm_req_valid !== 1'b0) begin fails++; $display("FAIL limit_block act=%0h exp=0", fm_req_valid); end
    repeat (3) tick;
    checks++; if (fm_req_valid !== 1'b0) begin fails++; $display("FAIL limit_hold act=%0h exp=0", fm_req_valid); end
    checks++; if (fmq_stall !== 1'b0) begin fails++; $display("FAIL limit_stall act=%0h exp=0", fmq_stall); end
    fm_rsp_valid = 1'b1; fm_rsp_tq_id = 3'd0;
    tick;
    fm_rsp_valid = 1'b0;
    checks++; if (fm_req_valid !== 1'b1 || fm_req_is_wr !== 1'b0) begin fails++; $display("FAIL limit_9th act=%0h/%0h exp=1/0", fm_req_valid, fm_req_is_wr); end
    checks++; if (fm_req_cl_addr !== 28'h208) begin fails++; $display("FAIL limit_9th_addr act=%0h exp=208", fm_req_cl_addr); end
    tick;
    checks++; if (fm_req_valid !== 1'b1 || fm_req_is_wr !== 1'b1) begin fails++; $display("FAIL limit_wr act=%0h/%0h exp=1/1", fm_req_valid, fm_req_is_wr); end
    checks++; if (fm_req_cl_addr !== 28'h2F0) begin fails++; $display("FAIL limit_wr_addr act=%0h exp=2f0", fm_req_cl_addr); end
    tick;
    fm_req_ready = 1'b0;
    checks++; if (fm_req_valid !== 1'b0) begin fails++; $display("FAIL limit_empty act=%0h exp=0", fm_req_valid); end
    fm_rsp_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      fm_rsp_tq_id = TW'(i + 1);
      tick;
    end
    fm_rsp_valid = 1'b0;
    checks++; if (fmq_err !== 1'b0) begin fails++; $display("FAIL limit_err act=%0h exp=0", fmq_err); end
  endtask

  task automatic test_backpressure;
    fm_req_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      evict_wr_valid = 1'b1; evict_wr_cl_addr = AW'(28'h300 + 2 * k);
      evict_wr_cl_data = DW'(k) + {32'hBEEF, 96'h0};
      miss_rd_valid = 1'b1; miss_rd_cl_addr = AW'(28'h301 + 2 * k); miss_rd_tq_id = TW'(k);
      #1;
      checks++; if (fmq_stall !== (k == 3)) begin fails++; $display("FAIL bp_stall%0d act=%0h exp=%0h", k, fmq_stall, (k == 3)); end
      tick;
    end
    evict_wr_valid = 1'b0; miss_rd_valid = 1'b0;
    repeat (6) tick;
    checks++; if (fmq_stall !== 1'b1) begin fails++; $display("FAIL bp_stall_full act=%0h exp=1", fmq_stall); end
    checks++; if (fmq_err !== 1'b0) begin fails++; $display("FAIL bp_err act=%0h exp=0", fmq_err); end
    checks++; if (fm_req_cl_addr !== 28'h300) begin fails++; $display("FAIL bp_head act=%0h exp=300", fm_req_cl_addr); end
  endtask

  task automatic test_overflow;
    miss_rd_valid = 1'b1; miss_rd_cl_addr = 28'h3FF; miss_rd_tq_id = 3'd7;
    tick;
    miss_rd_valid = 1'b0;
    checks++; if (fmq_err !== 1'b1) begin fails++; $display("FAIL ovf_err act=%0h exp=1", fmq_err); end
    fm_req_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      checks++; if (fm_req_is_wr !== ((j % 2) == 0)) begin fails++; $display("FAIL drain_iswr%0d act=%0h exp=%0h", j, fm_req_is_wr, ((j % 2) == 0)); end
      checks++; if (fm_req_cl_addr !== AW'(28'h300 + j)) begin fails++; $display("FAIL drain_addr%0d act=%0h exp=%0h", j, fm_req_cl_addr, 28'h300 + j); end
      tick;
    end
    fm_req_ready = 1'b0;
    checks++; if (fm_req_valid !== 1'b0) begin fails++; $display("FAIL ovf_dropped act=%0h exp=0", fm_req_valid); end
    checks++; if (fmq_err !== 1'b1) begin fails++; $display("FAIL ovf_sticky act=%0h exp=1", fmq_err); end
  endtask

  task automatic test_reset_mid;
    fm_req_ready = 1'b1;
    miss_rd_valid = 1'b1; miss_rd_tq_id = 3'd1; miss_rd_cl_addr = 28'h400;
    tick;
    miss_rd_tq_id = 3'd2; miss_rd_cl_addr = 28'h401;
    tick;
    miss_rd_valid = 1'b0;
    tick;
    fm_req_ready = 1'b0;
    evict_wr_valid = 1'b1; evict_wr_cl_addr = 28'h410; evict_wr_cl_data = {4{32'h5A5A_5A5A}};
    miss_rd_valid = 1'b1; miss_rd_cl_addr = 28'h411; miss_rd_tq_id = 3'd3;
    tick;
    evict_wr_valid = 1'b0; miss_rd_cl_addr = 28'h412; miss_rd_tq_id = 3'd4;
    tick;
    miss_rd_valid = 1'b0;
    checks++; if (fm_req_valid !== 1'b1 || fm_req_cl_addr !== 28'h410) begin fails++; $display("FAIL mid_pre act=%0h/%0h exp=1/410", fm_req_valid, fm_req_cl_addr); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (fm_req_valid !== 1'b0) begin fails++; $display("FAIL mid_vld act=%0h exp=0", fm_req_valid); end
    checks++; if (fm_req_cl_addr !== '0 || fm_req_is_wr !== 1'b0) begin fails++; $display("FAIL mid_payload act=%0h/%0h exp=0/0", fm_req_cl_addr, fm_req_is_wr); end
    checks++; if (fmq_err !== 1'b0) begin fails++; $display("FAIL mid_err act=%0h exp=0", fmq_err); end
    checks++; if (fmq_stall !== 1'b0) begin fails++; $display("FAIL mid_stall act=%0h exp=0", fmq_stall); end
    tick;
    rst = 1'b0;
    tick;
    checks++; if (fm_req_valid !== 1'b0) begin fails++; $display("FAIL mid_post act=%0h exp=0", fm_req_valid); end
    fm_rsp_valid = 1'b1; fm_rsp_tq_id = 3'd1;
    tick;
    fm_rsp_valid = 1'b0;
    checks++; if (fmq_err !== 1'b1) begin fails++; $display("FAIL orphan_err act=%0h exp=1", fmq_err); end
    repeat (3) tick;
    checks++; if (fmq_err !== 1'b1) begin fails++; $display("FAIL orphan_sticky act=%0h exp=1", fmq_err); end
  endtask

  initial begin
    rst = 1'b1;
    miss_rd_valid = 1'b0; miss_rd_tq_id = '0; miss_rd_cl_addr = '0;
    evict_wr_valid = 1'b0; evict_wr_cl_addr = '0; evict_wr_cl_data = '0;
    fm_req_ready = 1'b0; fm_rsp_valid = 1'b0; fm_rsp_tq_id = '0; fm_rsp_cl_data = '0;
    repeat (2) tick;
    test_reset;
    rst = 1'b0;
    tick;
    test_single_miss;
    test_order;
    test_outst_limit;
    test_backpressure;
    test_overflow;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
